door_plant: RTL and testbench

Behavioural-synthesizable model of the garage door mechanism, the other end of the `door` controller's motor/sensor interface. It consumes the motor drive lines `UP_m`/`DN_m`, integrates door position with a configurable travel speed, and produces the limit sensors `UP_max`/`DN_max` that feed back into `door`. It is the closed-loop plant for controller benches and FPGA demos, and it also reports conflicting-drive faults and limit overruns.

---
 rtl/door_plant.sv | 132 +++++++++++++
 tb/tb_door_plant.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/door_plant.sv
// Garage door plant: integrates door position from the UP_m/DN_m motor drives and
// produces the limit sensors, a state code, overrun pulses and a sticky conflict fault.
module door_plant #(
    parameter int POS_MAX    = 16,
    parameter int SPEED_DIV  = 4,
    parameter int RESET_OPEN = 0,
    parameter int POS_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             UP_m,
    input  logic             DN_m,
    output logic             UP_max,
    output logic             DN_max,
    output logic [POS_W-1:0] pos,
    output logic [2:0]       state,
    output logic             overrun,
    output logic             fault
);

    localparam int PW = $clog2(SPEED_DIV) + 1;
    localparam logic [PW-1:0]    DIV_M1    = PW'(SPEED_DIV - 1);
    localparam logic [POS_W-1:0] POS_TOP   = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_RESET = (RESET_OPEN != 0) ? POS_W'(POS_MAX) : {POS_W{1'b0}};

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_STOPPED = 3'd4,
        ST_FAULT   = 3'd5
    } door_state_t;

    localparam door_state_t ST_RESET = (RESET_OPEN != 0) ? ST_OPEN : ST_CLOSED;

    door_state_t      state_r, state_s;
    logic [POS_W-1:0] pos_r, pos_s;
    logic [PW-1:0]    presc_r, presc_s;
    logic [PW-1:0]    cnt_s;
    logic             fault_r, fault_s;
    logic             overrun_r, overrun_s;
    logic             up_max_r, dn_max_r;
    logic             last_up_r, last_dn_r;

    // Next position, prescaler, fault and state from the current drive inputs.
    always_comb begin
        pos_s     = pos_r;
        presc_s   = presc_r;
        fault_s   = fault_r;
        overrun_s = 1'b0;
        state_s   = state_r;
        // A reversal restarts the step from zero but this edge still counts.
        cnt_s     = ((UP_m && last_dn_r) || (DN_m && last_up_r)) ? {PW{1'b0}} : presc_r;
        if (fault_r) begin
            state_s = ST_FAULT;
        end else if (UP_m && DN_m) begin
            fault_s = 1'b1;
            state_s = ST_FAULT;
        end else begin
            if (UP_m) begin
                if (pos_r == POS_TOP) begin
                    overrun_s = 1'b1;
                    presc_s   = {PW{1'b0}};
                end else if (cnt_s == DIV_M1) begin
                    pos_s   = pos_r + {{(POS_W-1){1'b0}}, 1'b1};
                    presc_s = {PW{1'b0}};
                end else begin
                    presc_s = cnt_s + {{(PW-1){1'b0}}, 1'b1};
                end
            end else if (DN_m) begin
                if (pos_r == {POS_W{1'b0}}) begin
                    overrun_s = 1'b1;
                    presc_s   = {PW{1'b0}};
                end else if (cnt_s == DIV_M1) begin
                    pos_s   = pos_r - {{(POS_W-1){1'b0}}, 1'b1};
                    presc_s = {PW{1'b0}};
                end else begin
                    presc_s = cnt_s + {{(PW-1){1'b0}}, 1'b1};
                end
            end else begin
                presc_s = {PW{1'b0}};
            end

            if (pos_s == POS_TOP) begin
                state_s = ST_OPEN;
            end else if (pos_s == {POS_W{1'b0}}) begin
                state_s = ST_CLOSED;
            end else if (UP_m) begin
                state_s = ST_OPENING;
            end else if (DN_m) begin
                state_s = ST_CLOSING;
            end else begin
                state_s = ST_STOPPED;
            end
        end
    end

    // State register; limit sensors are registered from the next position so
    // they change in the same cycle as pos.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_r     <= POS_RESET;
            presc_r   <= {PW{1'b0}};
            state_r   <= ST_RESET;
            fault_r   <= 1'b0;
            overrun_r <= 1'b0;
            up_max_r  <= (POS_RESET == POS_TOP);
            dn_max_r  <= (POS_RESET == {POS_W{1'b0}});
            last_up_r <= 1'b0;
            last_dn_r <= 1'b0;
        end else begin
            pos_r     <= pos_s;
            presc_r   <= presc_s;
            state_r   <= state_s;
            fault_r   <= fault_s;
            overrun_r <= overrun_s;
            up_max_r  <= (pos_s == POS_TOP);
            dn_max_r  <= (pos_s == {POS_W{1'b0}});
            last_up_r <= fault_s ? last_up_r : UP_m;
            last_dn_r <= fault_s ? last_dn_r : DN_m;
        end
    end

    assign pos     = pos_r;
    assign state   = state_r;
    assign fault   = fault_r;
    assign overrun = overrun_r;
    assign UP_max  = up_max_r;
    assign DN_max  = dn_max_r;

endmodule

// File: tb/tb_door_plant.sv
// Directed bench for door_plant with POS_MAX=4, SPEED_DIV=2, closed reset position.
module tb_door_plant;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       UP_m = 1'b0;
    logic       DN_m = 1'b0;
    logic       UP_max, DN_max, overrun, fault;
    logic [7:0] pos;
    logic [2:0] state;

    int compared   = 0;
    int mismatched = 0;

    door_plant #(.POS_MAX(4), .SPEED_DIV(2), .RESET_OPEN(0), .POS_W(8)) dut (
        .clk(clk), .rst(rst), .UP_m(UP_m), .DN_m(DN_m),
        .UP_max(UP_max), .DN_max(DN_max), .pos(pos), .state(state),
        .overrun(overrun), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; UP_m = 1'b0; DN_m = 1'b0;
        tick(1);
        rst = 1'b1;
        compared += 6;
        if (pos !== 8'd0) begin mismatched++; $display("FAIL reset_pos got %0d want 0", pos); end
        if (DN_max !== 1'b1) begin mismatched++; $display("FAIL reset_dn_max got %b want 1", DN_max); end
        if (UP_max !== 1'b0) begin mismatched++; $display("FAIL reset_up_max got %b want 0", UP_max); end
        if (state !== 3'd0) begin mismatched++; $display("FAIL reset_state got %0d want 0", state); end
        if (fault !== 1'b0) begin mismatched++; $display("FAIL reset_fault got %b want 0", fault); end
        if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_full_open();
        UP_m = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            compared++;
            if (pos !== 8'(e / 2)) begin mismatched++; $display("FAIL open_pos edge %0d got %0d want %0d", e, pos, e / 2); end
        end
        compared += 3;
        if (UP_max !== 1'b1) begin mismatched++; $display("FAIL open_up_max got %b want 1", UP_max); end
        if (state !== 3'd2) begin mismatched++; $display("FAIL open_state got %0d want 2", state); end
        if (overrun !== 1'b0) begin mismatched++; $display("FAIL open_no_overrun got %b want 0", overrun); end
        for (int e = 9; e <= 10; e++) begin
            tick(1);
            compared += 2;
            if (overrun !== 1'b1) begin mismatched++; $display("FAIL overrun edge %0d got %b want 1", e, overrun); end
            if (pos !== 8'd4) begin mismatched++; $display("FAIL overrun_pos edge %0d got %0d want 4", e, pos); end
        end
    endtask

    task automatic test_partial_close();
        UP_m = 1'b0; DN_m = 1'b1;
        tick(1);
        compared += 3;
        if (pos !== 8'd4) begin mismatched++; $display("FAIL close_e1_pos got %0d want 4", pos); end
        if (UP_max !== 1'b1) begin mismatched++; $display("FAIL close_e1_up_max got %b want 1", UP_max); end
        if (overrun !== 1'b0) begin mismatched++; $display("FAIL close_e1_overrun got %b want 0", overrun); end
        tick(1);
        compared += 2;
        if (pos !== 8'd3) begin mismatched++; $display("FAIL close_e2_pos got %0d want 3", pos); end
        if (UP_max !== 1'b0) begin mismatched++; $display("FAIL close_e2_up_max got %b want 0", UP_max); end
        tick(1);
        compared += 2;
        if (pos !== 8'd3) begin mismatched++; $display("FAIL close_e3_pos got %0d want 3", pos); end
        if (state !== 3'd3) begin mismatched++; $display("FAIL close_state got %0d want 3", state); end
        DN_m = 1'b0;
        tick(1);
        compared++;
        if (state !== 3'd4) begin mismatched++; $display("FAIL stopped_state got %0d want 4", state); end
        DN_m = 1'b1;
        tick(1);
        compared++;
        if (pos !== 8'd3) begin mismatched++; $display("FAIL reclose_e1_pos got %0d want 3", pos); end
        tick(1);
        compared++;
        if (pos !== 8'd2) begin mismatched++; $display("FAIL reclose_e2_pos got %0d want 2", pos); end
    endtask

    task automatic test_reversal();
        DN_m = 1'b0; UP_m = 1'b1;
        tick(1);
        compared += 2;
        if (pos !== 8'd2) begin mismatched++; $display("FAIL rev_up_pos got %0d want 2", pos); end
        if (state !== 3'd1) begin mismatched++; $display("FAIL rev_up_state got %0d want 1", state); end
        UP_m = 1'b0; DN_m = 1'b1;
        tick(1);
        compared++;
        if (pos !== 8'd2) begin mismatched++; $display("FAIL rev_dn_e1_pos got %0d want 2", pos); end
        tick(1);
        compared++;
        if (pos !== 8'd1) begin mismatched++; $display("FAIL rev_dn_e2_pos got %0d want 1", pos); end
    endtask

    task automatic test_fault();
        DN_m = 1'b0; UP_m = 1'b1;
        tick(2);
        compared++;
        if (pos !== 8'd2) begin mismatched++; $display("FAIL fault_setup_pos got %0d want 2", pos); end
        DN_m = 1'b1;
        tick(1);
        compared += 3;
        if (fault !== 1'b1) begin mismatched++; $display("FAIL fault_set got %b want 1", fault); end
        if (state !== 3'd5) begin mismatched++; $display("FAIL fault_state got %0d want 5", state); end
        if (pos !== 8'd2) begin mismatched++; $display("FAIL fault_pos got %0d want 2", pos); end
        DN_m = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            compared += 4;
            if (pos !== 8'd2) begin mismatched++; $display("FAIL frozen_pos edge %0d got %0d want 2", e, pos); end
            if (overrun !== 1'b0) begin mismatched++; $display("FAIL frozen_overrun edge %0d got %b want 0", e, overrun); end
            if (fault !== 1'b1) begin mismatched++; $display("FAIL frozen_fault edge %0d got %b want 1", e, fault); end
            if (state !== 3'd5) begin mismatched++; $display("FAIL frozen_state edge %0d got %0d want 5", e, state); end
        end
        rst = 1'b0;
        tick(1);
        rst = 1'b1; UP_m = 1'b0;
        compared += 3;
        if (fault !== 1'b0) begin mismatched++; $display("FAIL fault_clear got %b want 0", fault); end
        if (pos !== 8'd0) begin mismatched++; $display("FAIL fault_reset_pos got %0d want 0", pos); end
        if (state !== 3'd0) begin mismatched++; $display("FAIL fault_reset_state got %0d want 0", state); end
    endtask

    task automatic test_reset_mid_travel();
        UP_m = 1'b1;
        tick(6);
        compared += 2;
        if (pos !== 8'd3) begin mismatched++; $display("FAIL mid_setup_pos got %0d want 3", pos); end
        if (DN_max !== 1'b0) begin mismatched++; $display("FAIL mid_setup_dn_max got %b want 0", DN_max); end
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        compared += 3;
        if (pos !== 8'd0) begin mismatched++; $display("FAIL mid_reset_pos got %0d want 0", pos); end
        if (state !== 3'd0) begin mismatched++; $display("FAIL mid_reset_state got %0d want 0", state); end
        if (DN_max !== 1'b1) begin mismatched++; $display("FAIL mid_reset_dn_max got %b want 1", DN_max); end
        tick(2);
        compared++;
        if (pos !== 8'd1) begin mismatched++; $display("FAIL post_reset_step got %0d want 1", pos); end
        UP_m = 1'b0;
    endtask

    initial begin
        tick(1);
        test_reset();
        test_full_open();
        test_partial_close();
        test_reversal();
        test_fault();
        test_reset_mid_travel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
